instr_issue_seq: RTL

- Instruction sequencer that drives the 16-bit instruction input of the simple CPU core.
- Holds a small loadable program memory and a program counter (PC).
- Issues one instruction per valid/ready handshake; on a handshake it also samples the core's Zero flag.
- Executes branch, jump and halt internally using the two low instruction bits. The core does not use these bits.

---
 rtl/instr_seq_pkg.sv | 27 ++
 rtl/instr_prog_mem.sv | 25 ++
 rtl/instr_issue_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction issue sequencer: instruction layout,
// CTRL codes and sequencer state encoding.
package instr_seq_pkg;

  localparam int INSTR_BITS = 16;

  // Field layout of one instruction word, MSB first.
  typedef struct packed {
    logic [1:0] src_a;      // [15:14]
    logic [1:0] src_b;      // [13:12]
    logic [1:0] dest;       // [11:10]
    logic [2:0] alu_op;     // [9:7]
    logic [3:0] imm;        // [6:3]
    logic       reg_write;  // [2]
    logic [1:0] ctrl;       // [1:0]
  } instr_t;

  localparam logic [1:0] CTRL_NORMAL = 2'b00;
  localparam logic [1:0] CTRL_BZ     = 2'b01;
  localparam logic [1:0] CTRL_JMP    = 2'b10;
  localparam logic [1:0] CTRL_HALT   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/instr_prog_mem.sv
// Program store: 2**ADDR_W words, one synchronous write port and one
// combinational read port; contents are deliberately not reset.
module instr_prog_mem
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = INSTR_BITS
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_issue_seq.sv
// Issues program words to the core over valid/ready; BZ/JMP/HALT are resolved here
// as one-cycle bubbles. Define ISSUE_COUNT_EN to add the issue_cnt output.
module instr_issue_seq
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = INSTR_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               zero_in,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy,
`ifdef ISSUE_COUNT_EN
  output logic [15:0]        issue_cnt,
`endif
  output logic               done
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              zero_q;
  instr_t            cur;
  logic              mem_we;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  // Program writes are only accepted while nothing is executing.
  assign mem_we = load_en && (state != ST_RUN);

  instr_prog_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (cur)
  );

  assign target = ADDR_W'(cur.imm);
  assign pc_inc = pc + ADDR_W'(1);

  // Derived from state, so instr_valid falls as soon as rst clears state.
  assign instr_valid = (state == ST_RUN) && (cur.ctrl == CTRL_NORMAL);
  assign instr_out   = instr_valid ? cur : '0;
  assign pc_out      = pc;
  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state  <= ST_RUN;
            pc     <= '0;
            zero_q <= 1'b0;
          end
        end
        ST_RUN: begin
          case (cur.ctrl)
            CTRL_NORMAL: begin
              if (instr_ready) begin
                zero_q <= zero_in;
                pc     <= pc_inc;
              end
            end
            CTRL_BZ:  pc    <= zero_q ? target : pc_inc;
            CTRL_JMP: pc    <= target;
            default:  state <= ST_HALTED;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ISSUE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if ((state != ST_RUN) && start) begin
      issue_cnt <= '0;
    end else if (instr_valid && instr_ready && (issue_cnt != 16'hFFFF)) begin
      issue_cnt <= issue_cnt + 16'd1;
    end
  end
`endif

endmodule
